// File: rtl/countdown_mmss.sv
// BCD minutes:seconds countdown timer (00:00..59:59) paced by a one-cycle tick.
// Runs, pauses, and raises a tick-timed alarm when the count reaches 00:00.
module countdown_mmss #(
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] D_min,
    input  logic [7:0] D_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] Q_min,
    output logic [7:0] Q_sec,
    output logic       running,
    output logic       done,
    output logic       Bo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_INIT = 8'(ALARM_TICKS);

    state_t     state, state_nxt;
    logic [7:0] min_nxt, sec_nxt;
    logic [7:0] alarm_cnt, alarm_cnt_nxt;
    logic [7:0] dec_min, dec_sec;
    logic       q_is_one;

    // Saturate an out-of-range BCD preset digit by digit.
    function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
        logic [3:0] tens, units;
        tens  = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
        units = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, units};
    endfunction

    // One-second BCD decrement with borrow rippling sec units -> min tens.
    always_comb begin
        logic b0, b1, b2;
        dec_sec = Q_sec;
        dec_min = Q_min;
        b0 = (Q_sec[3:0] == 4'd0);
        dec_sec[3:0] = b0 ? 4'd9 : Q_sec[3:0] - 4'd1;
        b1 = b0 && (Q_sec[7:4] == 4'd0);
        if (b0) dec_sec[7:4] = (Q_sec[7:4] == 4'd0) ? 4'd5 : Q_sec[7:4] - 4'd1;
        b2 = b1 && (Q_min[3:0] == 4'd0);
        if (b1) dec_min[3:0] = (Q_min[3:0] == 4'd0) ? 4'd9 : Q_min[3:0] - 4'd1;
        if (b2) dec_min[7:4] = (Q_min[7:4] == 4'd0) ? 4'd5 : Q_min[7:4] - 4'd1;
    end

    assign q_is_one = (Q_min == 8'h00) && (Q_sec == 8'h01);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        min_nxt       = Q_min;
        sec_nxt       = Q_sec;
        alarm_cnt_nxt = alarm_cnt;

        if (load) begin
            state_nxt     = IDLE;
            min_nxt       = clamp_bcd(D_min);
            sec_nxt       = clamp_bcd(D_sec);
            alarm_cnt_nxt = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!stop && start && ({Q_min, Q_sec} != 16'h0000))
                        state_nxt = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        if (q_is_one) begin
                            state_nxt     = ALARM;
                            min_nxt       = 8'h00;
                            sec_nxt       = 8'h00;
                            alarm_cnt_nxt = ALARM_INIT;
                        end else begin
                            min_nxt = dec_min;
                            sec_nxt = dec_sec;
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start)
                        state_nxt = RUN;
                end
                ALARM: begin
                    if (stop || start) begin
                        state_nxt     = IDLE;
                        alarm_cnt_nxt = 8'd0;
                    end else if (tick) begin
                        alarm_cnt_nxt = alarm_cnt - 8'd1;
                        if (alarm_cnt <= 8'd1) begin
                            state_nxt     = IDLE;
                            alarm_cnt_nxt = 8'd0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            Q_min     <= 8'h00;
            Q_sec     <= 8'h00;
            alarm_cnt <= 8'd0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            Q_min     <= min_nxt;
            Q_sec     <= sec_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            running   <= (state_nxt == RUN);
            done      <= (state_nxt == ALARM);
        end
    end

    assign Bo = (state == RUN) && tick && !stop && (Q_sec == 8'h00);

endmodule

// File: doc/countdown_mmss.md
# countdown_mmss

- BCD minutes:seconds down-counter, 00:00 to 59:59, paced by a one-cycle seconds tick.
- Counts the opposite direction to the clock's up-counting mod-6/mod-10/mod-60 chain: decrements digit by digit, borrows between digits, stops at 00:00 and raises a timed alarm.
- Provides the clock's countdown/timer mode; shares its `tick` source and the 7-segment display path with the time-of-day counters.

## Interface

Parameters:
- `ALARM_TICKS`, default 10: number of `tick` pulses `done` stays high after expiry; legal 1..255.

Ports:
- `clk`  in  1: system clock; all state changes on rising edge.
- `clrn`  in  1: asynchronous, active-low reset.
- `tick`  in  1: 1 Hz enable; one `clk` cycle wide.
- `load`  in  1: synchronous preset load.
- `D_min`  in  8: BCD preset minutes; [7:4] tens, [3:0] units.
- `D_sec`  in  8: BCD preset seconds; same packing.
- `start`  in  1: one-cycle pulse; run, resume, or acknowledge alarm.
- `stop`  in  1: one-cycle pulse; pause, or acknowledge alarm.
- `Q_min`  out  8: current minutes, BCD.
- `Q_sec`  out  8: current seconds, BCD.
- `running`  out  1: high in RUN.
- `done`  out  1: high in ALARM.
- `Bo`  out  1: seconds-to-minutes borrow, combinational.

## Operation

States are IDLE, RUN, PAUSE and ALARM. Reset state is IDLE.

Priority, high to low: `clrn`, `load`, `stop`, `start`, `tick`.

Load:
- `load`=1 in any state copies `D_min`/`D_sec` to `Q_min`/`Q_sec` and goes to IDLE.
- Clears alarm and `done`.
- Tens digits >5 load as 5; units digits >9 load as 9 (per digit, independent).

Transitions:
- IDLE: `start` with Q≠00:00 goes to RUN. `start` with Q=00:00 is ignored. `stop` is ignored.
- RUN: `stop` goes to PAUSE with no decrement, even if `tick` is also high.
- RUN, `tick` with no `stop`: decrement Q by one second.
  - If Q was 00:01, Q becomes 00:00, the state goes to ALARM, and the alarm count is loaded with `ALARM_TICKS`.
- PAUSE: `start` goes to RUN. `tick` and `stop` are ignored. Q holds.
- ALARM: each `tick` decrements the alarm count; the tick that reaches 0 goes to IDLE.
  - `start` or `stop` goes to IDLE immediately.
  - Q stays 00:00.
- `start` and `stop` in the same cycle: `stop` wins.
  - In IDLE, nothing happens.
  - In PAUSE, it stays PAUSE.

Decrement arithmetic, per BCD digit:
- Seconds units: 0 becomes 9 and borrows; otherwise subtract 1.
- Seconds tens: decrements only on borrow; 0 becomes 5 and borrows.
- Minutes units: decrements only on borrow; 0 becomes 9 and borrows.
- Minutes tens: decrements only on borrow; 0 becomes 5.
- Minutes-tens wrap is unreachable in RUN because the counter stops at 00:00.

`Bo` = RUN & `tick` & !`stop` & (`Q_sec`==8'h00).
- Mirrors the up-counter carry (`Co`) as a combinational enable-qualified pulse.
- Never asserts at Q=00:00, since RUN never holds 00:00.

## Timing

- `Q_min`, `Q_sec`, `running` and `done` are registered; they update one `clk` after the qualifying input edge.
- `Bo` is combinational, valid in the same cycle as `tick`.
- Reset values: `Q_min`=8'h00, `Q_sec`=8'h00, `running`=0, `done`=0, alarm count 0, state IDLE. `Bo`=0 while `clrn` is low.
- Reset mid-run: all outputs go to reset values asynchronously. After `clrn` deasserts, the block waits in IDLE for `load`/`start`.
- A `start` accepted in IDLE in the same cycle as `tick`: no decrement that cycle; the first decrement is on the next `tick`.
- Latency, expiry: the `tick` taking Q from 00:01 to 00:00 raises `done` on the following `clk` edge.
- `done` duration: `done` falls on the edge after the `ALARM_TICKS`-th subsequent `tick`.
- `load` while in RUN: the new value appears next cycle, state is IDLE, `running` falls.

## Test plan

- Reset/load: `clrn` low → Q=00:00, `running`=0, `done`=0. Release, then `load` with D=8'h12:8'h34 → Q=12:34, IDLE.
- Borrow chain: load 10:00, `start`, 1 `tick` → Q=09:59. `Bo`=1 during that tick.
  - Continue to 09:00 (59 more ticks), then 1 tick → 08:59 with `Bo`=1.
- Expiry/alarm: load 00:03, `ALARM_TICKS`=10, `start`, 3 ticks.
  - `done` rises one cycle after tick 3; Q=00:00; `running`=0.
  - After 10 more ticks: IDLE, `done`=0.
- Pause/resume: load 00:30, `start`, 5 ticks → 00:25. `stop` with a simultaneous `tick` → PAUSE, Q=00:25.
  - 3 ticks → still 00:25. `start`, 1 tick → 00:24.
- Invalid/edge inputs:
  - `start` at Q=00:00 → stays IDLE.
  - `load` D=8'h7A:8'hF3 → Q=59:53.
  - `start`+`stop` together in IDLE → IDLE.
  - `stop` in ALARM → IDLE, `done`=0 next cycle.
- Reset mid-operation: in RUN at 05:17, assert `clrn` asynchronously between edges → outputs zero immediately. Release, then a `tick` → no change.
